ov5640_pwr_seq_ctrl: RTL

OV5640_PWR_SEQ_CTRL -- requirements
Module: ov5640_pwr_seq_ctrl

---
 rtl/ov5640_pwr_seq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ov5640_pwr_seq_ctrl.sv
// OV5640 power-up / reset / configure / vsync-lock sequencer with bounded retries.
// Define OV5640_SEQ_WDT_EN to add a vsync watchdog in RUN; otherwise RUN is terminal.
module ov5640_pwr_seq_ctrl #(
    parameter int unsigned T_PWDN      = 250000,
    parameter int unsigned T_RST       = 25000,
    parameter int unsigned T_BOOT      = 500000,
    parameter int unsigned T_CFG_TO    = 25000000,
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned T_VS_TO     = 5000000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic       sw_restart,
    input  logic       cfg_done,
    input  logic       cmos_vsync_i,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       cfg_rst_n,
    output logic       stream_en,
    output logic       locked,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        StPwdn  = 3'd0,
        StRst   = 3'd1,
        StBoot  = 3'd2,
        StCfg   = 3'd3,
        StLock  = 3'd4,
        StRun   = 3'd5,
        StFault = 3'd6
    } state_e;

    localparam logic [24:0] PwdnLast = 25'(T_PWDN - 1);
    localparam logic [24:0] RstLast  = 25'(T_RST - 1);
    localparam logic [24:0] BootLast = 25'(T_BOOT - 1);
    localparam logic [24:0] CfgLast  = 25'(T_CFG_TO - 1);
    localparam logic [24:0] VsLast   = 25'(T_VS_TO - 1);
    localparam logic [3:0]  LockLast = 4'(LOCK_FRAMES - 1);
    localparam logic [3:0]  MaxRetry = 4'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [3:0]  edge_q, edge_d;
    logic [3:0]  retry_q, retry_d;
    logic        fail;

    logic vs_meta, vs_sync, vs_dly, vs_rise;

    // vs_rise is registered three edges after the asynchronous input rises.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_dly  <= 1'b0;
            vs_rise <= 1'b0;
        end else begin
            vs_meta <= cmos_vsync_i;
            vs_sync <= vs_meta;
            vs_dly  <= vs_sync;
            vs_rise <= vs_sync & ~vs_dly;
        end
    end

    // {cam_pwdn, cam_rst_n, cfg_rst_n, stream_en, locked, fault}
    function automatic logic [5:0] decode(state_e s);
        unique case (s)
            StPwdn:  return 6'b100000;
            StRst:   return 6'b000000;
            StBoot:  return 6'b010000;
            StCfg:   return 6'b011000;
            StLock:  return 6'b011100;
            StRun:   return 6'b011110;
            StFault: return 6'b100001;
            default: return 6'b100000;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 25'd1;
        edge_d  = edge_q;
        retry_d = retry_q;
        fail    = 1'b0;

        unique case (state_q)
            StPwdn: if (cnt_q == PwdnLast) state_d = StRst;
            StRst:  if (cnt_q == RstLast)  state_d = StBoot;
            StBoot: if (cnt_q == BootLast) state_d = StCfg;
            StCfg: begin
                if (cfg_done) begin
                    state_d = StLock;
                end else if (cnt_q == CfgLast) begin
                    fail = 1'b1;
                end
            end
            StLock: begin
                if (vs_rise) begin
                    cnt_d = '0;
                    if (edge_q == LockLast) begin
                        state_d = StRun;
                    end else begin
                        edge_d = edge_q + 4'd1;
                    end
                end else if (cnt_q == VsLast) begin
                    fail = 1'b1;
                end
            end
            StRun: begin
`ifdef OV5640_SEQ_WDT_EN
                if (vs_rise) begin
                    cnt_d = '0;
                end else if (cnt_q == VsLast) begin
                    fail = 1'b1;
                end
`else
                cnt_d = cnt_q;
`endif
            end
            StFault: cnt_d = cnt_q;
            default: state_d = StPwdn;
        endcase

        if (fail) begin
            if (retry_q == MaxRetry) begin
                state_d = StFault;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = StPwdn;
            end
        end

        if (state_d == StRun && state_q != StRun) begin
            retry_d = '0;
        end

        if (state_d != state_q) begin
            cnt_d  = '0;
            edge_d = '0;
        end

        // Restart overrides any failure or advance decided above.
        if (sw_restart) begin
            state_d = StPwdn;
            retry_d = '0;
            cnt_d   = '0;
            edge_d  = '0;
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPwdn;
            cnt_q   <= '0;
            edge_q  <= '0;
            retry_q <= '0;
            {cam_pwdn, cam_rst_n, cfg_rst_n, stream_en, locked, fault} <= 6'b100000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            retry_q <= retry_d;
            {cam_pwdn, cam_rst_n, cfg_rst_n, stream_en, locked, fault} <= decode(state_d);
        end
    end

    assign retry_cnt = retry_q;
    assign state_o   = state_q;

endmodule
